// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one variable-latency memory port between the
// instruction-fetch requester and the data requester. One transaction is in
// flight at a time, sequenced by an IDLE/ISSUE/WAIT/RESP FSM with a timeout.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration on ties;
// otherwise the data requester always wins ties.
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_ready,
  output logic        o_if_valid,
  output logic [31:0] o_if_rdata,
  output logic        o_if_err,
  input  logic        i_d_req,
  input  logic [31:0] i_d_addr,
  input  logic        i_d_ren,
  input  logic        i_d_wen,
  input  logic [31:0] i_d_wdata,
  input  logic [3:0]  i_d_mask,
  output logic        o_d_ready,
  output logic        o_d_valid,
  output logic [31:0] o_d_rdata,
  output logic        o_d_err,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_ready,
  input  logic        i_mem_valid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // Counter value on the last permitted ISSUE/WAIT cycle.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] tmo_cnt_q;
  logic        tmo_hit;
  logic        accept, pick_d, illegal, tie_pick_d;
  logic        mem_resp, tmo_fire;

  // Latched transaction fields; only observed through state-gated outputs.
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        ren_q, wen_q, err_q, grant_d_q;
  logic [3:0]  mask_q;

  // Address low bits are architecturally ignored.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{i_if_addr[1:0], i_d_addr[1:0]};

  assign tmo_hit = (tmo_cnt_q == TMO_LAST);

`ifdef MEM_ARB_RR_EN
  logic last_d_q;

  // Last-grant register: reset to data so fetch wins the first tie.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       last_d_q <= 1'b1;
    else if (accept) last_d_q <= pick_d;
  end

  assign tie_pick_d = ~last_d_q;
`else
  assign tie_pick_d = 1'b1;
`endif

  // Next-state logic, requester selection and ready pulses.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    pick_d     = 1'b0;
    illegal    = 1'b0;
    mem_resp   = 1'b0;
    tmo_fire   = 1'b0;
    o_if_ready = 1'b0;
    o_d_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!i_rst && (i_d_req || i_if_req)) begin
          accept = 1'b1;
          pick_d = (i_d_req && i_if_req) ? tie_pick_d : i_d_req;
          if (pick_d) begin
            o_d_ready = 1'b1;
            illegal   = (i_d_ren == i_d_wen);
            state_d   = illegal ? RESP : ISSUE;
          end else begin
            o_if_ready = 1'b1;
            state_d    = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (i_mem_ready) begin
          state_d = WAIT;
        end else if (tmo_hit) begin
          tmo_fire = 1'b1;
          state_d  = RESP;
        end
      end
      WAIT: begin
        if (i_mem_valid) begin
          mem_resp = 1'b1;
          state_d  = RESP;
        end else if (tmo_hit) begin
          tmo_fire = 1'b1;
          state_d  = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register and timeout counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      tmo_cnt_q <= 16'd0;
    end else begin
      state_q <= state_d;
      if (accept)
        tmo_cnt_q <= 16'd0;
      else if (state_q == ISSUE || state_q == WAIT)
        tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end
  end

  // Capture request fields on accept and the response on completion.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      grant_d_q <= pick_d;
      err_q     <= illegal;
      rdata_q   <= 32'd0;
      if (pick_d) begin
        addr_q  <= {i_d_addr[31:2], 2'b00};
        ren_q   <= i_d_ren;
        wen_q   <= i_d_wen;
        wdata_q <= i_d_wdata;
        mask_q  <= i_d_mask;
      end else begin
        addr_q  <= {i_if_addr[31:2], 2'b00};
        ren_q   <= 1'b1;
        wen_q   <= 1'b0;
        wdata_q <= 32'd0;
        mask_q  <= 4'b1111;
      end
    end else if (mem_resp) begin
      rdata_q <= wen_q ? 32'd0 : i_mem_rdata;
    end else if (tmo_fire) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b1;
    end
  end

  // Memory command is visible only while issuing; responses only in RESP.
  always_comb begin
    o_mem_req   = (state_q == ISSUE);
    o_mem_addr  = o_mem_req ? addr_q  : 32'd0;
    o_mem_ren   = o_mem_req & ren_q;
    o_mem_wen   = o_mem_req & wen_q;
    o_mem_wdata = o_mem_req ? wdata_q : 32'd0;
    o_mem_mask  = o_mem_req ? mask_q  : 4'd0;
    o_if_valid  = (state_q == RESP) & ~grant_d_q;
    o_d_valid   = (state_q == RESP) &  grant_d_q;
    o_if_rdata  = o_if_valid ? rdata_q : 32'd0;
    o_d_rdata   = o_d_valid  ? rdata_q : 32'd0;
    o_if_err    = o_if_valid & err_q;
    o_d_err     = o_d_valid  & err_q;
    o_busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (TIMEOUT_CYCLES = 8).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready, if_valid, if_err;
  logic [31:0] if_rdata;
  logic        d_req, d_ren, d_wen;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_mask;
  logic        d_ready, d_valid, d_err;
  logic [31:0] d_rdata;
  logic        mem_req, mem_ren, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_mask;
  logic        mem_ready, mem_valid;
  logic [31:0] mem_rdata;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ready(if_ready),
    .o_if_valid(if_valid), .o_if_rdata(if_rdata), .o_if_err(if_err),
    .i_d_req(d_req), .i_d_addr(d_addr), .i_d_ren(d_ren), .i_d_wen(d_wen),
    .i_d_wdata(d_wdata), .i_d_mask(d_mask), .o_d_ready(d_ready),
    .o_d_valid(d_valid), .o_d_rdata(d_rdata), .o_d_err(d_err),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr), .o_mem_ren(mem_ren),
    .o_mem_wen(mem_wen), .o_mem_wdata(mem_wdata), .o_mem_mask(mem_mask),
    .i_mem_ready(mem_ready), .i_mem_valid(mem_valid), .i_mem_rdata(mem_rdata),
    .o_busy(busy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic logic any_out();
    return |{if_ready, if_valid, if_rdata, if_err, d_ready, d_valid, d_rdata, d_err,
             mem_req, mem_addr, mem_ren, mem_wen, mem_wdata, mem_mask, busy};
  endfunction

  // Minimum-latency fetch: ready at cycle 1, valid at cycle 2, response at cycle 3.
  task automatic fetch_min(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp_addr, input logic [31:0] data);
    if_req = 1'b1; if_addr = addr;
    sample();
    check_val({tag, "_ready"}, 32'(if_ready), 32'd1);
    tick();
    if_req = 1'b0; if_addr = 32'hFFFF_FFFF; mem_ready = 1'b1;
    sample();
    check_val({tag, "_memreq"}, 32'(mem_req), 32'd1);
    check_val({tag, "_memaddr"}, mem_addr, exp_addr);
    check_val({tag, "_mask_ren_wen"}, 32'({mem_mask, mem_ren, mem_wen}), 32'h3E);
    tick();
    mem_ready = 1'b0; mem_valid = 1'b1; mem_rdata = data;
    sample();
    check_val({tag, "_wait_noreq"}, 32'(mem_req), 32'd0);
    tick();
    mem_valid = 1'b0; mem_rdata = 32'd0;
    sample();
    check_val({tag, "_valid"}, 32'(if_valid), 32'd1);
    check_val({tag, "_rdata"}, if_rdata, data);
    check_val({tag, "_err"}, 32'(if_err), 32'd0);
    tick();
    sample();
    check_val({tag, "_idle"}, 32'({if_valid, busy}), 32'd0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] exp_d_seq;
    rst = 1'b1; if_req = 1'b0; if_addr = 32'd0; d_req = 1'b0; d_addr = 32'd0;
    d_ren = 1'b0; d_wen = 1'b0; d_wdata = 32'd0; d_mask = 4'd0;
    mem_ready = 1'b0; mem_valid = 1'b0; mem_rdata = 32'd0;
    tick(); tick();
    sample();
    check_val("reset_outputs", 32'(any_out()), 32'd0);
    tick();
    rst = 1'b0;

    // Single fetch with unaligned address.
    fetch_min("fetch", 32'h0000_0103, 32'h0000_0100, 32'hDEAD_BEEF);

    // Byte store with one extra ISSUE cycle; write data from memory must be hidden.
    d_req = 1'b1; d_addr = 32'h0000_2003; d_ren = 1'b0; d_wen = 1'b1;
    d_mask = 4'b1000; d_wdata = 32'hAB00_0000;
    sample();
    check_val("store_ready", 32'({d_ready, if_ready}), 32'h2);
    tick();
    d_req = 1'b0; d_addr = 32'hFFFF_FFFF; d_wen = 1'b0; d_mask = 4'b0000; d_wdata = 32'd0;
    sample();
    check_val("store_memaddr", mem_addr, 32'h0000_2000);
    check_val("store_wdata", mem_wdata, 32'hAB00_0000);
    check_val("store_mask_ren_wen", 32'({mem_req, mem_mask, mem_ren, mem_wen}), 32'h61);
    tick();
    mem_ready = 1'b1;
    sample();
    check_val("store_issue_hold", 32'(mem_req), 32'd1);
    tick();
    mem_ready = 1'b0; mem_valid = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_valid = 1'b0;
    sample();
    check_val("store_valid", 32'({d_valid, if_valid}), 32'h2);
    check_val("store_rdata", d_rdata, 32'd0);
    check_val("store_err", 32'(d_err), 32'd0);
    tick();

    // Contention: both requesters held across three transactions.
`ifdef MEM_ARB_RR_EN
    exp_d_seq = 3'b010;
`else
    exp_d_seq = 3'b111;
`endif
    if_req = 1'b1; if_addr = 32'h0000_1000;
    d_req = 1'b1; d_addr = 32'h0000_3000; d_ren = 1'b1; d_wen = 1'b0; d_mask = 4'b1111;
    for (int t = 0; t < 3; t++) begin
      sample();
      check_val($sformatf("cont%0d_grant", t), 32'({d_ready, if_ready}),
                exp_d_seq[t] ? 32'h2 : 32'h1);
      tick();
      mem_ready = 1'b1;
      sample();
      check_val($sformatf("cont%0d_addr", t), mem_addr,
                exp_d_seq[t] ? 32'h0000_3000 : 32'h0000_1000);
      tick();
      mem_ready = 1'b0; mem_valid = 1'b1; mem_rdata = 32'hC0DE_0000 + 32'(t);
      tick();
      mem_valid = 1'b0;
      sample();
      check_val($sformatf("cont%0d_resp", t), 32'({d_valid, if_valid, d_ready, if_ready}),
                exp_d_seq[t] ? 32'h8 : 32'h4);
      check_val($sformatf("cont%0d_rdata", t), exp_d_seq[t] ? d_rdata : if_rdata,
                32'hC0DE_0000 + 32'(t));
      tick();
    end
    if_req = 1'b0; d_req = 1'b0; d_ren = 1'b0;

    // Timeout: memory never ready; error response 9 cycles after accept.
    if_req = 1'b1; if_addr = 32'h0000_0040;
    sample();
    check_val("tmo_ready", 32'(if_ready), 32'd1);
    tick();
    if_req = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      sample();
      check_val($sformatf("tmo_req_c%0d", c), 32'({mem_req, if_valid}), 32'h2);
      tick();
    end
    sample();
    check_val("tmo_memreq_drop", 32'(mem_req), 32'd0);
    check_val("tmo_valid_err", 32'({if_valid, if_err}), 32'h3);
    check_val("tmo_rdata", if_rdata, 32'd0);
    tick();

    // Illegal data op (ren == wen): no memory command, error next cycle.
    d_req = 1'b1; d_addr = 32'h0000_4000; d_ren = 1'b1; d_wen = 1'b1;
    sample();
    check_val("ill_accept", 32'({d_ready, mem_req}), 32'h2);
    tick();
    d_req = 1'b0; d_ren = 1'b0; d_wen = 1'b0;
    sample();
    check_val("ill_memreq", 32'(mem_req), 32'd0);
    check_val("ill_valid_err", 32'({d_valid, d_err}), 32'h3);
    check_val("ill_rdata", d_rdata, 32'd0);
    tick();
    sample();
    check_val("ill_idle", 32'(busy), 32'd0);
    tick();

    // Reset while waiting on memory, then a stray response.
    if_req = 1'b1; if_addr = 32'h0000_0500;
    tick();
    if_req = 1'b0; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    sample();
    check_val("rstw_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_val("rstw_outputs", 32'(any_out()), 32'd0);
    tick();
    rst = 1'b0; mem_valid = 1'b1; mem_rdata = 32'h0000_0BAD;
    sample();
    check_val("rstw_stray1", 32'({if_valid, d_valid, busy}), 32'd0);
    tick();
    mem_valid = 1'b0; mem_rdata = 32'd0;
    sample();
    check_val("rstw_stray2", 32'({if_valid, d_valid, busy}), 32'd0);
    tick();
    fetch_min("post_rst", 32'h0000_0604, 32'h0000_0604, 32'h600D_600D);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one variable-latency memory port between the hart's instruction-fetch requester and its data (load/store) requester. It sits between the hart and a realistic backing memory, replacing the separate combinational imem/dmem ports. Each requester gets a request/accept/response handshake. At most one memory transaction is in flight at a time, sequenced by a four-state FSM with a response timeout.

## Interface
- TIMEOUT_CYCLES, 255: cycles in ISSUE+WAIT before an error response is forced; legal range 1..65535.
- i_clk  in  1  global clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_if_req  in  1  fetch request; held until o_if_ready.
- i_if_addr  in  32  fetch address; bits [1:0] ignored (forced 0).
- o_if_ready  out  1  one-cycle pulse: fetch request captured.
- o_if_valid  out  1  one-cycle pulse: fetch response valid.
- o_if_rdata  out  32  fetch data; valid with o_if_valid.
- o_if_err  out  1  fetch timed out; valid with o_if_valid.
- i_d_req  in  1  data request; held until o_d_ready.
- i_d_addr  in  32  data address; bits [1:0] forced 0.
- i_d_ren, i_d_wen  in  1 each  read / write select.
- i_d_wdata  in  32  write data, pre-shifted to byte lanes.
- i_d_mask  in  4  byte-lane mask.
- o_d_ready  out  1  one-cycle pulse: data request captured.
- o_d_valid  out  1  one-cycle pulse: data response (reads and writes).
- o_d_rdata  out  32  read data; 0 for writes and errors.
- o_d_err  out  1  timeout, or illegal ren==wen.
- o_mem_req  out  1  memory command valid.
- o_mem_addr  out  32  word-aligned address.
- o_mem_ren, o_mem_wen  out  1 each  read / write strobe.
- o_mem_wdata  out  32  write data.
- o_mem_mask  out  4  byte mask; 4'b1111 for fetch.
- i_mem_ready  in  1  memory accepts command this cycle.
- i_mem_valid  in  1  memory response valid; sampled only in WAIT.
- i_mem_rdata  in  32  response data.
- o_busy  out  1  FSM not in IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: choose a requester (priority below), pulse its ready combinationally, and latch addr/ren/wen/wdata/mask plus a grant bit.
  - Legal request: go to ISSUE.
  - Data request with i_d_ren==i_d_wen: go to RESP with err=1 and issue nothing.
- ISSUE: drive o_mem_req=1 with the latched fields. On i_mem_ready, go to WAIT.
- WAIT: on i_mem_valid, latch i_mem_rdata (0 if the latched op is a write) and go to RESP.
- RESP: assert the granted requester's valid/rdata/err for one cycle, then return to IDLE. Ready outputs are 0 in this cycle.
- Timeout: a 16-bit counter clears on entry to ISSUE and increments each cycle in ISSUE/WAIT. When it reaches TIMEOUT_CYCLES: go to RESP with err=1, rdata=0, and drop o_mem_req.
- Default priority: data before fetch when both request in IDLE.
- All mem outputs are 0 outside ISSUE. Response outputs are 0 outside RESP.

## Timing
- Reset value is 0 on every output. On reset the FSM goes to IDLE, the timeout counter clears, and the last-grant register is set to data.
- Reset mid-transaction abandons the transaction. Later i_mem_valid pulses are ignored because the FSM is in IDLE.
- Minimum latency: request accepted at cycle 0, i_mem_ready at cycle 1, i_mem_valid at cycle 2, response at cycle 3.
- Illegal data op: accepted at cycle 0, o_d_err response at cycle 1.
- i_mem_valid in the same cycle as i_mem_ready (still ISSUE) is ignored. Memory must respond in a later cycle.
- Requesters must hold request fields stable until ready. Fields are don't-care after acceptance.
- No new request is accepted until the cycle after RESP. Back-to-back throughput is one transaction per 4 cycles minimum.

## Configuration
- MEM_ARB_RR_EN defined: round-robin. A last-grant register updates on each accept. When both requesters are active in IDLE, the one not granted last wins. After reset, fetch wins the first tie.
- Undefined: fixed priority, data always wins ties. The last-grant register is not synthesized.

## Test plan
- Single fetch: i_if_addr=0x00000103, memory ready at cycle 1, valid at cycle 2 with 0xDEADBEEF -> o_mem_addr=0x00000100, mask 4'b1111, ren=1; o_if_valid at cycle 3 with rdata 0xDEADBEEF, err=0.
- Byte store: addr 0x2003, wen=1, mask 4'b1000, wdata 0xAB000000 -> o_mem_addr=0x2000 with the same mask/wdata; o_d_valid with rdata 0, err=0.
- Contention: both requesters held for 3 transactions -> default grant order D,D,D; with MEM_ARB_RR_EN, grant order F,D,F.
- Timeout: TIMEOUT_CYCLES=8, memory never ready -> o_mem_req drops and o_if_valid=1 with o_if_err=1, rdata=0, 9 cycles after accept.
- Illegal op: i_d_ren=1 and i_d_wen=1 -> o_mem_req stays 0; o_d_valid with o_d_err=1 the next cycle.
- Reset in WAIT: assert i_rst, then send i_mem_valid -> all outputs 0, o_busy=0, no response pulse; the next fetch completes normally.
